// File: rtl/cpu_data_mem.sv
`timescale 1ns/1ps
// cpu_data_mem: 256 x 19-bit data memory for the MEM stage.
// Synchronous write, combinational gated read, asynchronous active-low clear.
module cpu_data_mem #(
  parameter int unsigned DATA_W = 19,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MEM_memwrite,
  input  logic              MEM_memread,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] w_rword;

  // Storage: whole array clears while reset is low; otherwise capture one word per enabled edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (MEM_memwrite) begin
      r_mem[addr] <= wdata;
    end
  end

  // Read path: no bypass, so a same-address write shows up only after the edge.
  always_comb begin
    w_rword = r_mem[addr];
    rdata   = MEM_memread ? w_rword : '0;
  end

endmodule

// File: tb/tb_cpu_data_mem.sv
`timescale 1ns/1ps
// Self-checking bench for cpu_data_mem against an array-based reference model.
module tb_cpu_data_mem;

  logic        clk;
  logic        reset;
  logic        MEM_memwrite;
  logic        MEM_memread;
  logic [7:0]  addr;
  logic [18:0] wdata;
  logic [18:0] rdata;

  int unsigned n_checks;
  int unsigned n_errors;

  // Reference model: what each address should hold.
  logic [18:0] model [256];

  cpu_data_mem #(
    .DATA_W (19),
    .ADDR_W (8),
    .DEPTH  (256)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .MEM_memwrite (MEM_memwrite),
    .MEM_memread  (MEM_memread),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model[i] = 19'h0;
  endtask

  // One write cycle: drive at negedge, capture on posedge, release at next negedge.
  task automatic do_write(input logic [7:0] a, input logic [18:0] d);
    @(negedge clk);
    MEM_memread  = 1'b0;
    MEM_memwrite = 1'b1;
    addr         = a;
    wdata        = d;
    @(negedge clk);
    MEM_memwrite = 1'b0;
    model[a]     = d;
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    MEM_memwrite = 1'b0;
    MEM_memread  = 1'b0;
    addr         = '0;
    wdata        = '0;
    model_clear();
    repeat (5) @(negedge clk);
    MEM_memread = 1'b1;
    addr        = 8'h10;
    #1;
    n_checks++;
    if (rdata !== 19'h0) begin
      n_errors++;
      $display("FAIL reset_held: rdata=%h expected %h", rdata, 19'h0);
    end
    reset = 1'b1;
    foreach (model[i]) begin end
    for (int k = 0; k < 4; k++) begin
      logic [7:0] sweep [4];
      sweep = '{8'h00, 8'h10, 8'h20, 8'hFF};
      addr = sweep[k];
      #1;
      n_checks++;
      if (rdata !== 19'h0) begin
        n_errors++;
        $display("FAIL reset_sweep addr=%h: rdata=%h expected %h", addr, rdata, 19'h0);
      end
    end
    MEM_memread = 1'b0;
    #1;
    n_checks++;
    if (rdata !== 19'h0) begin
      n_errors++;
      $display("FAIL reset_read_off: rdata=%h expected %h", rdata, 19'h0);
    end
  endtask

  task automatic test_write_read();
    do_write(8'h10, 19'h1A5A5);
    MEM_memread = 1'b1;
    addr        = 8'h10;
    #1;
    n_checks++;
    if (rdata !== 19'h1A5A5) begin
      n_errors++;
      $display("FAIL wr_rd_0x10: rdata=%h expected %h", rdata, 19'h1A5A5);
    end
    addr = 8'h11;
    #1;
    n_checks++;
    if (rdata !== 19'h0) begin
      n_errors++;
      $display("FAIL wr_rd_0x11: rdata=%h expected %h", rdata, 19'h0);
    end
  endtask

  task automatic test_isolation();
    do_write(8'h20, 19'h2B3C4);
    MEM_memread = 1'b1;
    addr        = 8'h20;
    #1;
    n_checks++;
    if (rdata !== 19'h2B3C4) begin
      n_errors++;
      $display("FAIL iso_0x20: rdata=%h expected %h", rdata, 19'h2B3C4);
    end
    addr = 8'h10;
    #1;
    n_checks++;
    if (rdata !== 19'h1A5A5) begin
      n_errors++;
      $display("FAIL iso_0x10: rdata=%h expected %h", rdata, 19'h1A5A5);
    end
    MEM_memread = 1'b0;
    #1;
    n_checks++;
    if (rdata !== 19'h0) begin
      n_errors++;
      $display("FAIL iso_read_off: rdata=%h expected %h", rdata, 19'h0);
    end
  endtask

  task automatic test_boundary();
    do_write(8'hFF, 19'h7FFFF);
    do_write(8'h00, 19'h00001);
    MEM_memread = 1'b1;
    addr        = 8'hFF;
    #1;
    n_checks++;
    if (rdata !== 19'h7FFFF) begin
      n_errors++;
      $display("FAIL bound_0xFF: rdata=%h expected %h", rdata, 19'h7FFFF);
    end
    addr = 8'h00;
    #1;
    n_checks++;
    if (rdata !== 19'h00001) begin
      n_errors++;
      $display("FAIL bound_0x00: rdata=%h expected %h", rdata, 19'h00001);
    end
    addr = 8'hFE;
    #1;
    n_checks++;
    if (rdata !== 19'h0) begin
      n_errors++;
      $display("FAIL bound_0xFE: rdata=%h expected %h", rdata, 19'h0);
    end
  endtask

  task automatic test_same_addr();
    @(negedge clk);
    MEM_memread  = 1'b1;
    MEM_memwrite = 1'b1;
    addr         = 8'h10;
    wdata        = 19'h05555;
    #1;
    n_checks++;
    if (rdata !== 19'h1A5A5) begin
      n_errors++;
      $display("FAIL same_before: rdata=%h expected %h", rdata, 19'h1A5A5);
    end
    @(posedge clk);
    #1;
    model[8'h10] = 19'h05555;
    n_checks++;
    if (rdata !== 19'h05555) begin
      n_errors++;
      $display("FAIL same_after: rdata=%h expected %h", rdata, 19'h05555);
    end
    @(negedge clk);
    MEM_memwrite = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    MEM_memread  = 1'b1;
    MEM_memwrite = 1'b1;
    addr         = 8'h30;
    wdata        = 19'h3CAFE;
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    addr = 8'h10;
    #1;
    n_checks++;
    if (rdata !== 19'h0) begin
      n_errors++;
      $display("FAIL async_clear_0x10: rdata=%h expected %h", rdata, 19'h0);
    end
    // Hold reset through an edge with the write still requested: must be ignored.
    addr = 8'h30;
    @(posedge clk);
    #1;
    n_checks++;
    if (rdata !== 19'h0) begin
      n_errors++;
      $display("FAIL async_write_ignored: rdata=%h expected %h", rdata, 19'h0);
    end
    MEM_memwrite = 1'b0;
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int a = 0; a < 256; a++) begin
      addr = 8'(a);
      #1;
      n_checks++;
      if (rdata !== model[a]) begin
        n_errors++;
        $display("FAIL async_sweep addr=%h: rdata=%h expected %h", addr, rdata, model[a]);
      end
    end
  endtask

  task automatic test_random();
    logic        we;
    logic        re;
    logic [7:0]  a;
    logic [18:0] d;
    logic [18:0] exp;
    for (int n = 0; n < 400; n++) begin
      we = 1'($urandom);
      re = ($urandom_range(0, 3) != 0);
      a  = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      d  = 19'($urandom);
      @(negedge clk);
      MEM_memwrite = we;
      MEM_memread  = re;
      addr         = a;
      wdata        = d;
      #1;
      exp = re ? model[a] : 19'h0;
      n_checks++;
      if (rdata !== exp) begin
        n_errors++;
        $display("FAIL rand_pre n=%0d addr=%h: rdata=%h expected %h", n, a, rdata, exp);
      end
      @(posedge clk);
      #1;
      if (we) model[a] = d;
      exp = re ? model[a] : 19'h0;
      n_checks++;
      if (rdata !== exp) begin
        n_errors++;
        $display("FAIL rand_post n=%0d addr=%h: rdata=%h expected %h", n, a, rdata, exp);
      end
    end
    @(negedge clk);
    MEM_memwrite = 1'b0;
    MEM_memread  = 1'b1;
    for (int a2 = 0; a2 < 256; a2++) begin
      addr = 8'(a2);
      #1;
      n_checks++;
      if (rdata !== model[a2]) begin
        n_errors++;
        $display("FAIL rand_sweep addr=%h: rdata=%h expected %h", addr, rdata, model[a2]);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_write_read();
    test_isolation();
    test_boundary();
    test_same_addr();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_data_mem.md
# cpu_data_mem

Single-clock 256 × 19-bit data memory for the MEM stage of the 19-bit pipelined CPU. Stores one 19-bit word per 8-bit address. Writes are synchronous on the clock edge; reads are combinational and gated by the read enable. An asynchronous active-low reset clears the whole array to zero.

## Interface

Parameters:
- `DATA_W`, default 19: word width in bits.
- `ADDR_W`, default 8: address width in bits.
- `DEPTH`, default 256 (2^ADDR_W): number of words.

Ports:
- `clk`: input, 1 bit. The single clock; all writes occur on its rising edge.
- `reset`: input, 1 bit. Asynchronous, active-low. While `reset` is 0, the array is cleared and held at zero.
- `MEM_memwrite`: input, 1 bit. Write enable, sampled on the rising edge of `clk`.
- `MEM_memread`: input, 1 bit. Read enable. It is level-sensitive and combinational.
- `addr`: input, 8 bits (ADDR_W). Word address, shared by read and write.
- `wdata`: input, 19 bits (DATA_W). Write data.
- `rdata`: output, 19 bits (DATA_W). Read data.

## Operation

Storage:
- `mem[0:DEPTH-1]`, each word DATA_W bits wide.
- All 256 addresses are valid. There is no out-of-range case and no wrap logic.

Reset:
- When `reset` goes to 0, every word is cleared to 19'h00000 immediately, without waiting for a clock edge.
- While `reset` is 0, all writes are ignored.
- After `reset` returns to 1, the first write can occur on the next rising edge of `clk`.

Write:
- Occurs on the rising edge of `clk` when `reset` is 1 and `MEM_memwrite` is 1: `mem[addr] <= wdata`.
- No other word changes.

Read:
- `rdata = MEM_memread ? mem[addr] : 19'h00000`. This path is purely combinational.
- When `MEM_memread` is 0, `rdata` is forced to zero. It never presents stale data.

Simultaneous read and write to the same address:
- Before the clock edge, `rdata` shows the old contents.
- After the edge, `rdata` shows the new `wdata`. There is no internal bypass.

Both enables low: the memory contents are unchanged and `rdata` is 0.

X handling: an address or data input containing X must not corrupt words other than the addressed word. Implementations may rely on the standard simulator semantics for this.

## Timing

Reset values:
- Every word is 0.
- `rdata` is 0 whether `MEM_memread` is 0, or 1 at any address.

Latencies:
- Write latency is 1 edge. Data is visible on `rdata` (with `MEM_memread` = 1) in the same cycle immediately after the capturing edge.
- Read latency is 0 cycles. `rdata` follows changes on `addr` and `MEM_memread` within combinational delay.

Handshake:
- There is none. Requests are single-cycle and always accepted.
- The enables must be stable around the rising edge of `clk`.

Reset in mid-operation:
- An assertion of `reset` coincident with a write edge wins. The word stays 0.
- Deasserting `reset` mid-cycle has no effect until the next edge.

## Test plan

1. **Reset.** Assert `reset` = 0 for 5 cycles, then release. Set `MEM_memread` = 1 and sweep `addr` over 0x00, 0x10, 0x20, 0xFF. Required: `rdata` = 0x00000 at every address.
2. **Write and read back, first address.** Write `addr` = 0x10, `wdata` = 0x1A5A5 for one edge. Then set `MEM_memwrite` = 0, `MEM_memread` = 1, `addr` = 0x10. Required: `rdata` = 0x1A5A5. With `addr` = 0x11, required: `rdata` = 0x00000.
3. **Second address and isolation.** Write 0x2B3C4 to 0x20, then read 0x20 and 0x10. Required: 0x2B3C4 and 0x1A5A5 respectively. Drop `MEM_memread` to 0. Required: `rdata` = 0 immediately.
4. **Boundary and width.** Write 0x7FFFF to 0xFF and 0x00001 to 0x00, then read both. Required: exact values returned, with all 19 bits preserved.
5. **Same-address read during write.** Hold `MEM_memread` = 1 on 0x10 and write 0x05555 there. Required: `rdata` = 0x1A5A5 before the edge and 0x05555 after it.
6. **Asynchronous reset mid-operation.** After test 5, pulse `reset` = 0 between clock edges while a write to 0x30 is pending. Required: all words read back as 0, including 0x10 and 0x30. The pending write is not captured.
